// File: rtl/aes_param_engine.sv
// rtl/aes_param_engine.sv - iterative AES-128/192/256 engine with expanded round-key file
module aes_param_engine #(
    parameter int KEY_BITS   = 128,
    parameter int SBOX_LANES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                key_valid,
    output logic                key_ready,
    input  logic [KEY_BITS-1:0] key_in,
    output logic                key_loaded,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_decrypt,
    input  logic [127:0]        in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [127:0]        out_data,
    output logic                busy
);
    localparam int NK = KEY_BITS / 32;
    localparam int NR = NK + 6;
    localparam int NW = 4 * (NR + 1);
    localparam int S  = 16 / SBOX_LANES;

    generate
        if (!(KEY_BITS == 128 || KEY_BITS == 192 || KEY_BITS == 256)) begin : g_bad_key
            $error("aes_param_engine: KEY_BITS must be 128, 192 or 256");
        end
        if (!(SBOX_LANES == 1 || SBOX_LANES == 2 || SBOX_LANES == 4 ||
              SBOX_LANES == 8 || SBOX_LANES == 16)) begin : g_bad_lanes
            $error("aes_param_engine: SBOX_LANES must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    typedef enum logic [2:0] {
        ST_IDLE, ST_KEXP, ST_ARK0, ST_SUB, ST_SHIFT, ST_MIX, ST_ARK, ST_HOLD
    } state_t;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = a;
        for (int i = 1; i < 8; i++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] rol(input logic [7:0] b, input int n);
        return 8'((b << n) | (b >> (8 - n)));
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] b, input logic inv);
        logic [7:0] x;
        if (!inv) begin
            x = ginv(b);
            return x ^ rol(x, 1) ^ rol(x, 2) ^ rol(x, 3) ^ rol(x, 4) ^ 8'h63;
        end
        x = rol(b, 1) ^ rol(b, 3) ^ rol(b, 6) ^ 8'h05;
        return ginv(x);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24], 1'b0), sbox(w[23:16], 1'b0),
                sbox(w[15:8], 1'b0), sbox(w[7:0], 1'b0)};
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
        logic [127:0] o;
        int src;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                src = inv ? ((c + 4 - r) % 4) : ((c + r) % 4);
                o[127 - 8*(r + 4*c) -: 8] = s[127 - 8*(r + 4*src) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s, input logic inv);
        logic [127:0] o;
        logic [7:0]   a [4];
        logic [7:0]   m [4];
        m[0] = inv ? 8'h0e : 8'h02;
        m[1] = inv ? 8'h0b : 8'h03;
        m[2] = inv ? 8'h0d : 8'h01;
        m[3] = inv ? 8'h09 : 8'h01;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) a[r] = s[127 - 8*(r + 4*c) -: 8];
            for (int r = 0; r < 4; r++)
                o[127 - 8*(r + 4*c) -: 8] = gmul(a[r], m[0]) ^ gmul(a[(r+1)%4], m[1]) ^
                                            gmul(a[(r+2)%4], m[2]) ^ gmul(a[(r+3)%4], m[3]);
        end
        return o;
    endfunction

    state_t        r_fsm;
    logic [31:0]   r_rk [NW];
    logic [127:0]  r_st;
    logic [127:0]  r_out_data;
    logic          r_out_valid;
    logic          r_key_loaded;
    logic          r_dec;
    logic [3:0]    r_round;
    logic [3:0]    r_lane;
    logic [5:0]    r_widx;
    logic [2:0]    r_kmod;
    logic [7:0]    r_rcon;

    logic [5:0]    w_rki;
    logic [127:0]  w_rk;
    logic [127:0]  w_ark;
    logic [127:0]  w_sub_st;
    logic [3:0]    w_sel    [SBOX_LANES];
    logic [7:0]    w_sb_out [SBOX_LANES];
    logic [31:0]   w_prev;
    logic [31:0]   w_old;
    logic [31:0]   w_sw;
    logic [31:0]   w_temp;
    logic          w_idle;

    assign w_idle     = (r_fsm == ST_IDLE);
    assign key_ready  = w_idle & ~rst;
    assign in_ready   = w_idle & ~rst & r_key_loaded & ~key_valid;
    assign busy       = ~w_idle;
    assign key_loaded = r_key_loaded;
    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;

    assign w_rki = {r_round, 2'b00};
    assign w_rk  = {r_rk[w_rki], r_rk[w_rki + 6'd1], r_rk[w_rki + 6'd2], r_rk[w_rki + 6'd3]};
    assign w_ark = r_st ^ w_rk;

    // Schedule word i: RotWord+SubWord+Rcon at i mod NK == 0, bare SubWord at i mod 8 == 4 (AES-256).
    assign w_prev = r_rk[r_widx - 6'd1];
    assign w_old  = r_rk[r_widx - 6'(NK)];
    assign w_sw   = sub_word((r_kmod == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev);
    assign w_temp = (r_kmod == 3'd0)           ? (w_sw ^ {r_rcon, 24'h0}) :
                    (NK == 8 && r_kmod == 3'd4) ? w_sw : w_prev;

    generate
        for (genvar j = 0; j < SBOX_LANES; j++) begin : g_lane
            assign w_sel[j]    = 4'(int'(r_lane) * SBOX_LANES + j);
            assign w_sb_out[j] = sbox(r_st[127 - 8*w_sel[j] -: 8], r_dec);
        end
    endgenerate

    always_comb begin
        w_sub_st = r_st;
        for (int j = 0; j < SBOX_LANES; j++)
            w_sub_st[127 - 8*w_sel[j] -: 8] = w_sb_out[j];
    end

    // Round-key file carries no reset; key_loaded guards its contents.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (w_idle && key_valid) begin
                for (int i = 0; i < NK; i++)
                    r_rk[i] <= key_in[KEY_BITS - 1 - 32*i -: 32];
            end else if (r_fsm == ST_KEXP) begin
                r_rk[r_widx] <= w_old ^ w_temp;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm        <= ST_IDLE;
            r_key_loaded <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_st         <= '0;
            r_dec        <= 1'b0;
            r_round      <= 4'd0;
            r_lane       <= 4'd0;
            r_widx       <= 6'd0;
            r_kmod       <= 3'd0;
            r_rcon       <= 8'h01;
        end else begin
            case (r_fsm)
                ST_IDLE: begin
                    if (key_valid) begin
                        r_key_loaded <= 1'b0;
                        r_widx       <= 6'(NK);
                        r_kmod       <= 3'd0;
                        r_rcon       <= 8'h01;
                        r_fsm        <= ST_KEXP;
                    end else if (in_valid && r_key_loaded) begin
                        r_st    <= in_data;
                        r_dec   <= in_decrypt;
                        r_round <= in_decrypt ? 4'(NR) : 4'd0;
                        r_fsm   <= ST_ARK0;
                    end
                end
                ST_KEXP: begin
                    r_widx <= r_widx + 6'd1;
                    r_kmod <= (r_kmod == 3'(NK - 1)) ? 3'd0 : r_kmod + 3'd1;
                    if (r_kmod == 3'd0) r_rcon <= xt(r_rcon);
                    if (r_widx == 6'(NW - 1)) begin
                        r_key_loaded <= 1'b1;
                        r_fsm        <= ST_IDLE;
                    end
                end
                ST_ARK0: begin
                    r_st    <= w_ark;
                    r_lane  <= 4'd0;
                    r_round <= r_dec ? r_round - 4'd1 : r_round + 4'd1;
                    r_fsm   <= r_dec ? ST_SHIFT : ST_SUB;
                end
                ST_SUB: begin
                    r_st   <= w_sub_st;
                    r_lane <= r_lane + 4'd1;
                    if (r_lane == 4'(S - 1)) begin
                        r_lane <= 4'd0;
                        r_fsm  <= r_dec ? ST_ARK : ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    r_st <= shift_rows(r_st, r_dec);
                    if (r_dec) r_fsm <= ST_SUB;
                    else       r_fsm <= (r_round == 4'(NR)) ? ST_ARK : ST_MIX;
                end
                ST_MIX: begin
                    r_st <= mix_columns(r_st, r_dec);
                    if (r_dec) begin
                        r_round <= r_round - 4'd1;
                        r_fsm   <= ST_SHIFT;
                    end else begin
                        r_fsm <= ST_ARK;
                    end
                end
                ST_ARK: begin
                    r_st <= w_ark;
                    if (r_dec ? (r_round == 4'd0) : (r_round == 4'(NR))) begin
                        r_out_data  <= w_ark;
                        r_out_valid <= 1'b1;
                        r_fsm       <= ST_HOLD;
                    end else if (r_dec) begin
                        r_fsm <= ST_MIX;
                    end else begin
                        r_round <= r_round + 4'd1;
                        r_fsm   <= ST_SUB;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_fsm       <= ST_IDLE;
                    end
                end
                default: r_fsm <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_param_engine.sv
// tb/tb_aes_param_engine.sv - directed known-answer bench for aes_param_engine
module tb_aes_param_engine;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K0   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT0  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] KF   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PTF  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CTF  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic         a_rst, a_key_valid, a_key_ready, a_key_loaded;
    logic         a_in_valid, a_in_ready, a_in_decrypt, a_out_valid, a_out_ready, a_busy;
    logic [127:0] a_key_in, a_in_data, a_out_data;

    aes_param_engine #(.KEY_BITS(128), .SBOX_LANES(4)) u_a (
        .clk(clk), .rst(a_rst), .key_valid(a_key_valid), .key_ready(a_key_ready),
        .key_in(a_key_in), .key_loaded(a_key_loaded), .in_valid(a_in_valid),
        .in_ready(a_in_ready), .in_decrypt(a_in_decrypt), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .busy(a_busy)
    );

    logic         x_rst, x_key_valid, x_in_valid, x_in_decrypt, x_out_ready;
    logic [127:0] x_key128, x_d128, x_d192, x_d256;
    logic [191:0] x_key192;
    logic [255:0] x_key256;
    logic [5:0]   m_kr, m_kl, m_ir, m_ov, m_busy;
    logic [127:0] m_od [6];

    generate
        for (genvar g = 0; g < 4; g++) begin : g_sweep
            aes_param_engine #(.KEY_BITS(128), .SBOX_LANES(g < 2 ? (1 << g) : (1 << (g + 1)))) u_sw (
                .clk(clk), .rst(x_rst), .key_valid(x_key_valid), .key_ready(m_kr[g]),
                .key_in(x_key128), .key_loaded(m_kl[g]), .in_valid(x_in_valid),
                .in_ready(m_ir[g]), .in_decrypt(x_in_decrypt), .in_data(x_d128),
                .out_valid(m_ov[g]), .out_ready(x_out_ready), .out_data(m_od[g]), .busy(m_busy[g])
            );
        end
    endgenerate

    aes_param_engine #(.KEY_BITS(192), .SBOX_LANES(4)) u_192 (
        .clk(clk), .rst(x_rst), .key_valid(x_key_valid), .key_ready(m_kr[4]),
        .key_in(x_key192), .key_loaded(m_kl[4]), .in_valid(x_in_valid),
        .in_ready(m_ir[4]), .in_decrypt(x_in_decrypt), .in_data(x_d192),
        .out_valid(m_ov[4]), .out_ready(x_out_ready), .out_data(m_od[4]), .busy(m_busy[4])
    );

    aes_param_engine #(.KEY_BITS(256), .SBOX_LANES(4)) u_256 (
        .clk(clk), .rst(x_rst), .key_valid(x_key_valid), .key_ready(m_kr[5]),
        .key_in(x_key256), .key_loaded(m_kl[5]), .in_valid(x_in_valid),
        .in_ready(m_ir[5]), .in_decrypt(x_in_decrypt), .in_data(x_d256),
        .out_valid(m_ov[5]), .out_ready(x_out_ready), .out_data(m_od[5]), .busy(m_busy[5])
    );

    int           exp_lat [6] = '{190, 110, 50, 40, 84, 98};
    int           exp_kl  [6] = '{41, 41, 41, 41, 47, 53};
    int           mx_lat  [6];
    logic [127:0] mx_dat  [6];

    task automatic load_key_a(input logic [127:0] k, output int cyc);
        a_key_in = k;
        a_key_valid = 1'b1;
        @(negedge clk);
        a_key_valid = 1'b0;
        cyc = 1;
        while (!a_key_loaded && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic send_block_a(input logic dec, input logic [127:0] d,
                                output int lat, output logic [127:0] res, output logic acc);
        int n;
        a_in_decrypt = dec;
        a_in_data = d;
        a_in_valid = 1'b1;
        #1;
        n = 0;
        while (!a_in_ready && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        acc = a_in_ready;
        @(negedge clk);
        a_in_valid = 1'b0;
        lat = 0;
        while (!a_out_valid && lat < 400) begin
            @(negedge clk);
            lat++;
        end
        res = a_out_data;
    endtask

    task automatic test_reset;
        a_rst = 1'b1; x_rst = 1'b1;
        a_key_valid = 1'b0; a_in_valid = 1'b0; a_in_decrypt = 1'b0; a_out_ready = 1'b1;
        a_key_in = '0; a_in_data = '0;
        x_key_valid = 1'b0; x_in_valid = 1'b0; x_in_decrypt = 1'b0; x_out_ready = 1'b1;
        x_key128 = '0; x_key192 = '0; x_key256 = '0; x_d128 = '0; x_d192 = '0; x_d256 = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({a_key_ready, a_in_ready, a_key_loaded, a_out_valid, a_busy} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags got %b want 00000",
                     {a_key_ready, a_in_ready, a_key_loaded, a_out_valid, a_busy});
        end
        checks++;
        if (a_out_data !== 128'h0) begin
            errors++;
            $display("FAIL reset_out_data got %h want 0", a_out_data);
        end
        a_rst = 1'b0; x_rst = 1'b0;
        #1;
        checks++;
        if ({a_key_ready, a_in_ready, a_busy} !== 3'b100) begin
            errors++;
            $display("FAIL post_reset_idle got %b want 100", {a_key_ready, a_in_ready, a_busy});
        end
    endtask

    task automatic test_key_expansion;
        int cyc;
        load_key_a(KF, cyc);
        checks++;
        if (cyc != 41) begin
            errors++;
            $display("FAIL kexp_latency got %0d want 41", cyc);
        end
        checks++;
        if (u_a.r_rk[43] !== 32'hb6630ca6) begin
            errors++;
            $display("FAIL kexp_w43 got %h want b6630ca6", u_a.r_rk[43]);
        end
    endtask

    task automatic test_encrypt;
        int lat; logic [127:0] res; logic acc;
        send_block_a(1'b0, PTF, lat, res, acc);
        checks++;
        if (acc !== 1'b1 || res !== CTF) begin
            errors++;
            $display("FAIL enc_fips got %h want %h (accepted %b)", res, CTF, acc);
        end
        checks++;
        if (lat != 70) begin
            errors++;
            $display("FAIL enc_latency got %0d want 70", lat);
        end
        @(negedge clk);
        checks++;
        if ({a_out_valid, a_busy} !== 2'b00) begin
            errors++;
            $display("FAIL enc_release got %b want 00", {a_out_valid, a_busy});
        end
    endtask

    task automatic test_key_priority;
        int lat; logic [127:0] res; logic acc;
        a_key_in = K0; a_key_valid = 1'b1;
        a_in_data = PT; a_in_decrypt = 1'b0; a_in_valid = 1'b1;
        #1;
        checks++;
        if ({a_key_ready, a_in_ready} !== 2'b10) begin
            errors++;
            $display("FAIL prio_ready got %b want 10", {a_key_ready, a_in_ready});
        end
        @(negedge clk);
        a_key_valid = 1'b0;
        #1;
        checks++;
        if ({a_key_loaded, a_busy, a_in_ready} !== 3'b010) begin
            errors++;
            $display("FAIL prio_stall got %b want 010", {a_key_loaded, a_busy, a_in_ready});
        end
        send_block_a(1'b0, PT, lat, res, acc);
        checks++;
        if (acc !== 1'b1 || res !== CT0 || lat != 70) begin
            errors++;
            $display("FAIL prio_result got %h lat %0d want %h lat 70", res, lat, CT0);
        end
        @(negedge clk);
    endtask

    task automatic test_decrypt;
        int lat; logic [127:0] res; logic acc;
        send_block_a(1'b1, CT0, lat, res, acc);
        checks++;
        if (acc !== 1'b1 || res !== PT) begin
            errors++;
            $display("FAIL dec_128 got %h want %h", res, PT);
        end
        checks++;
        if (lat != 70) begin
            errors++;
            $display("FAIL dec_latency got %0d want 70", lat);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int lat; logic [127:0] res; logic acc; logic stable_bad; logic ready_bad;
        a_out_ready = 1'b0;
        send_block_a(1'b0, PT, lat, res, acc);
        a_in_decrypt = 1'b1; a_in_data = CT0; a_in_valid = 1'b1;
        stable_bad = 1'b0; ready_bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (a_out_data !== CT0 || a_out_valid !== 1'b1) stable_bad = 1'b1;
            if (a_in_ready !== 1'b0 || a_key_ready !== 1'b0) ready_bad = 1'b1;
        end
        checks++;
        if (stable_bad) begin
            errors++;
            $display("FAIL hold_stable got %h valid %b want %h valid 1", a_out_data, a_out_valid, CT0);
        end
        checks++;
        if (ready_bad) begin
            errors++;
            $display("FAIL hold_readies got in %b key %b want 0 0", a_in_ready, a_key_ready);
        end
        a_out_ready = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if ({a_busy, a_in_ready, a_out_valid} !== 3'b010) begin
            errors++;
            $display("FAIL b2b_idle got %b want 010", {a_busy, a_in_ready, a_out_valid});
        end
        @(negedge clk);
        a_in_valid = 1'b0;
        checks++;
        if (a_busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accept got busy %b want 1", a_busy);
        end
        lat = 0;
        while (!a_out_valid && lat < 400) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (a_out_data !== PT || lat != 70) begin
            errors++;
            $display("FAIL b2b_result got %h lat %0d want %h lat 70", a_out_data, lat, PT);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_abort;
        int cyc; int lat; logic [127:0] res; logic acc; logic bad;
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 0) begin
                a_in_data = PT; a_in_decrypt = 1'b0; a_in_valid = 1'b1;
                @(negedge clk);
                a_in_valid = 1'b0;
                repeat (30) @(negedge clk);
            end else begin
                a_key_in = K0; a_key_valid = 1'b1;
                @(negedge clk);
                a_key_valid = 1'b0;
                repeat (20) @(negedge clk);
            end
            checks++;
            if (a_busy !== 1'b1) begin
                errors++;
                $display("FAIL abort_pre_busy pass %0d got %b want 1", pass, a_busy);
            end
            a_rst = 1'b1;
            @(negedge clk);
            a_rst = 1'b0;
            #1;
            checks++;
            if ({a_busy, a_out_valid, a_key_loaded} !== 3'b000 || a_out_data !== 128'h0) begin
                errors++;
                $display("FAIL abort_state pass %0d got %b data %h want 000 data 0",
                         pass, {a_busy, a_out_valid, a_key_loaded}, a_out_data);
            end
            a_in_valid = 1'b1;
            bad = 1'b0;
            for (int i = 0; i < 10; i++) begin
                #1;
                if (a_in_ready !== 1'b0 || a_busy !== 1'b0) bad = 1'b1;
                @(negedge clk);
            end
            a_in_valid = 1'b0;
            checks++;
            if (bad) begin
                errors++;
                $display("FAIL abort_no_accept pass %0d got in_ready %b busy %b want 0 0",
                         pass, a_in_ready, a_busy);
            end
        end
        load_key_a(K0, cyc);
        send_block_a(1'b0, PT, lat, res, acc);
        checks++;
        if (cyc != 41 || res !== CT0) begin
            errors++;
            $display("FAIL abort_recover got kexp %0d ct %h want 41 %h", cyc, res, CT0);
        end
        @(negedge clk);
    endtask

    task automatic run_multi(input logic dec);
        int lat;
        logic [5:0] got;
        x_in_decrypt = dec;
        x_d128 = dec ? CT0 : PT;
        x_d192 = dec ? CT192 : PT;
        x_d256 = dec ? CT256 : PT;
        x_in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            mx_lat[i] = -1;
            mx_dat[i] = '0;
        end
        @(negedge clk);
        x_in_valid = 1'b0;
        lat = 0;
        got = '0;
        while (got != 6'h3f && lat < 400) begin
            @(negedge clk);
            lat++;
            for (int i = 0; i < 6; i++) begin
                if (m_ov[i] && !got[i]) begin
                    got[i] = 1'b1;
                    mx_lat[i] = lat;
                    mx_dat[i] = m_od[i];
                end
            end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_multi;
        int cyc;
        int kl_at [6];
        logic [127:0] exp_ct [6];
        exp_ct = '{CT0, CT0, CT0, CT0, CT192, CT256};
        checks++;
        if (m_kr !== 6'h3f) begin
            errors++;
            $display("FAIL multi_key_ready got %b want 111111", m_kr);
        end
        x_key128 = K0;
        x_key192 = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
        x_key256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
        x_key_valid = 1'b1;
        @(negedge clk);
        x_key_valid = 1'b0;
        cyc = 1;
        for (int i = 0; i < 6; i++) kl_at[i] = 0;
        while (m_kl != 6'h3f && cyc < 300) begin
            @(negedge clk);
            cyc++;
            for (int i = 0; i < 6; i++) if (m_kl[i] && kl_at[i] == 0) kl_at[i] = cyc;
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (kl_at[i] != exp_kl[i]) begin
                errors++;
                $display("FAIL multi_kexp[%0d] got %0d want %0d", i, kl_at[i], exp_kl[i]);
            end
        end
        checks++;
        if (m_ir !== 6'h3f) begin
            errors++;
            $display("FAIL multi_in_ready got %b want 111111", m_ir);
        end
        run_multi(1'b0);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (mx_dat[i] !== exp_ct[i] || mx_lat[i] != exp_lat[i]) begin
                errors++;
                $display("FAIL multi_enc[%0d] got %h lat %0d want %h lat %0d",
                         i, mx_dat[i], mx_lat[i], exp_ct[i], exp_lat[i]);
            end
        end
        run_multi(1'b1);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (mx_dat[i] !== PT || mx_lat[i] != exp_lat[i]) begin
                errors++;
                $display("FAIL multi_dec[%0d] got %h lat %0d want %h lat %0d",
                         i, mx_dat[i], mx_lat[i], PT, exp_lat[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_key_expansion();
        test_encrypt();
        test_key_priority();
        test_decrypt();
        test_back_to_back();
        test_reset_abort();
        test_multi();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
